// File: rtl/cmsdk_ahb_output_arbiter.sv
// rtl/cmsdk_ahb_output_arbiter.sv - AHB output-stage port arbiter with burst and lock hold
module cmsdk_ahb_output_arbiter #(
  parameter int NUM_PORTS        = 4,
  parameter int PORT_W           = 2,
  parameter int ARB_MODE         = 1,
  parameter int INCR_BEATS       = 4,
  parameter int EARLY_INCR_LIMIT = 1
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic                 no_port,
  output logic                 arb_change,
  output logic [3:0]           burst_remain
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  // Beats still to come after the NONSEQ of an undefined-length INCR
  localparam logic [3:0] LP_INCR_LOAD   = 4'(INCR_BEATS - 2);
  localparam logic [1:0] LP_EARLY_LIMIT = 2'(EARLY_INCR_LIMIT);

  logic [PORT_W-1:0] r_addr;
  logic              r_no;
  logic              r_chg;
  logic [3:0]        r_remain;
  logic              r_hold;
  logic [1:0]        r_early;

  logic              w_hold_nxt;
  logic [3:0]        w_remain_nxt;
  logic [1:0]        w_early_nxt;
  logic              w_no_nxt;
  logic [PORT_W-1:0] w_addr_nxt;

  logic              w_cur_valid;
  logic              w_low_found;
  logic              w_below_found;
  logic              w_above_found;
  logic              w_rr_found;
  logic [PORT_W-1:0] w_low_idx;
  logic [PORT_W-1:0] w_below_idx;
  logic [PORT_W-1:0] w_above_idx;
  logic [PORT_W-1:0] w_rr_idx;

  // Burst tracking: how many beats remain and whether the grant must be held
  always_comb begin
    w_hold_nxt   = r_hold;
    w_remain_nxt = r_remain;
    if (!HSELM) begin
      w_hold_nxt   = 1'b0;
      w_remain_nxt = 4'd0;
    end else begin
      case (HTRANSM)
        TR_IDLE: begin
          w_hold_nxt   = 1'b0;
          w_remain_nxt = 4'd0;
        end
        TR_BUSY: begin
          w_hold_nxt   = r_hold;
          w_remain_nxt = r_remain;
        end
        TR_SEQ: begin
          if (r_remain == 4'd0) begin
            w_hold_nxt   = 1'b0;
            w_remain_nxt = 4'd0;
          end else begin
            w_remain_nxt = r_remain - 4'd1;
          end
        end
        TR_NONSEQ: begin
          case (HBURSTM)
            3'b000: begin
              w_hold_nxt   = 1'b0;
              w_remain_nxt = 4'd0;
            end
            3'b001: begin
              // Repeatedly cut-short INCR bursts lose their protection
              if (r_early == LP_EARLY_LIMIT) begin
                w_hold_nxt   = 1'b0;
                w_remain_nxt = 4'd0;
              end else begin
                w_hold_nxt   = 1'b1;
                w_remain_nxt = LP_INCR_LOAD;
              end
            end
            3'b010, 3'b011: begin
              w_hold_nxt   = 1'b1;
              w_remain_nxt = 4'd2;
            end
            3'b100, 3'b101: begin
              w_hold_nxt   = 1'b1;
              w_remain_nxt = 4'd6;
            end
            default: begin
              w_hold_nxt   = 1'b1;
              w_remain_nxt = 4'd14;
            end
          endcase
        end
        default: begin
          w_hold_nxt   = 1'b0;
          w_remain_nxt = 4'd0;
        end
      endcase
    end
  end

  // Count NONSEQs that interrupt a still-held burst, saturating at 3
  always_comb begin
    w_early_nxt = r_early;
    if (!w_hold_nxt) begin
      w_early_nxt = 2'd0;
    end else if (r_hold && (HTRANSM == TR_NONSEQ)) begin
      w_early_nxt = (r_early == 2'd3) ? 2'd3 : r_early + 2'd1;
    end
  end

  // Candidate winners: lowest overall, lowest below/above current, nearest after current
  always_comb begin
    int c;
    int best;
    int d;
    c             = int'(r_addr);
    best          = NUM_PORTS;
    d             = 0;
    w_cur_valid   = !r_no && (c < NUM_PORTS);
    w_low_found   = 1'b0;
    w_below_found = 1'b0;
    w_above_found = 1'b0;
    w_rr_found    = 1'b0;
    w_low_idx     = '0;
    w_below_idx   = '0;
    w_above_idx   = '0;
    w_rr_idx      = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_port[i]) begin
        w_low_found = 1'b1;
        w_low_idx   = PORT_W'(i);
        if (i < c) begin
          w_below_found = 1'b1;
          w_below_idx   = PORT_W'(i);
        end
        if (i > c) begin
          w_above_found = 1'b1;
          w_above_idx   = PORT_W'(i);
        end
      end
    end
    // Round-robin distance measured upward from the current port, wrapping
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req_port[i] && (i != c)) begin
        d = (i > c) ? (i - c) : (i - c + NUM_PORTS);
        if (d < best) begin
          best       = d;
          w_rr_found = 1'b1;
          w_rr_idx   = PORT_W'(i);
        end
      end
    end
  end

  // Next selection: held under lock or burst, otherwise arbitrate
  always_comb begin
    w_no_nxt   = r_no;
    w_addr_nxt = r_addr;
    if (HMASTLOCKM || w_hold_nxt) begin
      w_no_nxt   = r_no;
      w_addr_nxt = r_addr;
    end else if (!w_cur_valid) begin
      if (w_low_found) begin
        w_no_nxt   = 1'b0;
        w_addr_nxt = w_low_idx;
      end else begin
        w_no_nxt   = 1'b1;
      end
    end else if (ARB_MODE == 1) begin
      if (w_rr_found) begin
        w_no_nxt   = 1'b0;
        w_addr_nxt = w_rr_idx;
      end else if (HSELM) begin
        w_no_nxt   = 1'b0;
      end else begin
        w_no_nxt   = 1'b1;
      end
    end else begin
      if (w_below_found) begin
        w_no_nxt   = 1'b0;
        w_addr_nxt = w_below_idx;
      end else if (HSELM) begin
        w_no_nxt   = 1'b0;
      end else if (w_above_found) begin
        w_no_nxt   = 1'b0;
        w_addr_nxt = w_above_idx;
      end else begin
        w_no_nxt   = 1'b1;
      end
    end
  end

  // State advances only on completed transfers; arb_change flags a new selection
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_addr   <= '0;
      r_no     <= 1'b1;
      r_chg    <= 1'b0;
      r_remain <= 4'd0;
      r_hold   <= 1'b0;
      r_early  <= 2'd0;
    end else begin
      r_chg <= 1'b0;
      if (HREADYM) begin
        r_addr   <= w_addr_nxt;
        r_no     <= w_no_nxt;
        r_remain <= w_remain_nxt;
        r_hold   <= w_hold_nxt;
        r_early  <= w_early_nxt;
        r_chg    <= ({w_no_nxt, w_addr_nxt} != {r_no, r_addr});
      end
    end
  end

  assign addr_in_port = r_addr;
  assign no_port      = r_no;
  assign arb_change   = r_chg;
  assign burst_remain = r_remain;

endmodule

// File: tb/tb_cmsdk_ahb_output_arbiter.sv
// tb/tb_cmsdk_ahb_output_arbiter.sv - randomized model-checked bench for the output arbiter
module tb_cmsdk_ahb_output_arbiter;

  logic       HCLK = 1'b0;
  logic       HRESET = 1'b1;
  logic [3:0] req_port = 4'd0;
  logic       HREADYM = 1'b0;
  logic       HSELM = 1'b0;
  logic [1:0] HTRANSM = 2'd0;
  logic [2:0] HBURSTM = 3'd0;
  logic       HMASTLOCKM = 1'b0;

  logic [1:0] rr_addr, fx_addr;
  logic       rr_no, fx_no, rr_chg, fx_chg;
  logic [3:0] rr_rem, fx_rem;

  always #5 HCLK = ~HCLK;

  cmsdk_ahb_output_arbiter #(
    .NUM_PORTS(4), .PORT_W(2), .ARB_MODE(1), .INCR_BEATS(4), .EARLY_INCR_LIMIT(1)
  ) u_rr (
    .HCLK(HCLK), .HRESET(HRESET), .req_port(req_port), .HREADYM(HREADYM),
    .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
    .addr_in_port(rr_addr), .no_port(rr_no), .arb_change(rr_chg), .burst_remain(rr_rem)
  );

  cmsdk_ahb_output_arbiter #(
    .NUM_PORTS(4), .PORT_W(2), .ARB_MODE(0), .INCR_BEATS(4), .EARLY_INCR_LIMIT(1)
  ) u_fx (
    .HCLK(HCLK), .HRESET(HRESET), .req_port(req_port), .HREADYM(HREADYM),
    .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
    .addr_in_port(fx_addr), .no_port(fx_no), .arb_change(fx_chg), .burst_remain(fx_rem)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: index 0 = round-robin instance, 1 = fixed-priority instance
  int m_rem;
  int m_early;
  bit m_hold;
  bit m_no[2];
  int m_addr[2];
  bit m_chg[2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rem   = 0;
    m_early = 0;
    m_hold  = 1'b0;
    for (int m = 0; m < 2; m++) begin
      m_no[m]   = 1'b1;
      m_addr[m] = 0;
      m_chg[m]  = 1'b0;
    end
  endtask

  // One clock of the reference: burst bookkeeping then per-mode arbitration
  task automatic model_tick();
    int nr;
    int ne;
    bit nh;
    int beats;
    logic [3:0] rq;
    rq = req_port;
    if (!HREADYM) begin
      m_chg[0] = 1'b0;
      m_chg[1] = 1'b0;
      return;
    end
    nh = m_hold;
    nr = m_rem;
    if (!HSELM || HTRANSM == 2'd0) begin
      nh = 1'b0; nr = 0;
    end else if (HTRANSM == 2'd3) begin
      if (nr == 0) nh = 1'b0;
      else nr = nr - 1;
    end else if (HTRANSM == 2'd2) begin
      if (HBURSTM == 3'd0) begin
        nh = 1'b0; nr = 0;
      end else if (HBURSTM == 3'd1) begin
        if (m_early == 1) begin nh = 1'b0; nr = 0; end
        else begin nh = 1'b1; nr = 4 - 2; end
      end else begin
        beats = 4 << ((int'(HBURSTM) - 2) / 2);
        nh = 1'b1;
        nr = beats - 2;
      end
    end
    if (!nh) ne = 0;
    else if (m_hold && HTRANSM == 2'd2) ne = (m_early < 3) ? m_early + 1 : 3;
    else ne = m_early;

    for (int m = 0; m < 2; m++) begin
      bit nno;
      int na;
      int found;
      nno   = m_no[m];
      na    = m_addr[m];
      found = -1;
      if (!(HMASTLOCKM || nh)) begin
        if (m_no[m] || m_addr[m] >= 4) begin
          for (int p = 0; p < 4; p++) if (found < 0 && rq[p[1:0]]) found = p;
          if (found >= 0) begin nno = 1'b0; na = found; end
          else nno = 1'b1;
        end else if (m == 0) begin
          for (int k = 1; k < 4; k++) begin
            int p;
            p = (m_addr[m] + k) % 4;
            if (found < 0 && rq[p[1:0]]) found = p;
          end
          if (found >= 0) begin nno = 1'b0; na = found; end
          else if (HSELM) nno = 1'b0;
          else nno = 1'b1;
        end else begin
          for (int p = 0; p < m_addr[m]; p++) if (found < 0 && rq[p[1:0]]) found = p;
          if (found >= 0) begin nno = 1'b0; na = found; end
          else if (HSELM) nno = 1'b0;
          else begin
            for (int p = m_addr[m] + 1; p < 4; p++) if (found < 0 && rq[p[1:0]]) found = p;
            if (found >= 0) begin nno = 1'b0; na = found; end
            else nno = 1'b1;
          end
        end
      end
      m_chg[m]  = (nno != m_no[m]) || (na != m_addr[m]);
      m_no[m]   = nno;
      m_addr[m] = na;
    end
    m_hold  = nh;
    m_rem   = nr;
    m_early = ne;
  endtask

  task automatic check_all();
    check_val("rr_addr", 32'(rr_addr), 32'(m_addr[0]));
    check_val("rr_no",   32'(rr_no),   32'(m_no[0]));
    check_val("rr_chg",  32'(rr_chg),  32'(m_chg[0]));
    check_val("rr_rem",  32'(rr_rem),  32'(m_rem));
    check_val("fx_addr", 32'(fx_addr), 32'(m_addr[1]));
    check_val("fx_no",   32'(fx_no),   32'(m_no[1]));
    check_val("fx_chg",  32'(fx_chg),  32'(m_chg[1]));
    check_val("fx_rem",  32'(fx_rem),  32'(m_rem));
  endtask

  // Drive one cycle of inputs just after an edge, advance, then compare
  task automatic step(input logic [3:0] rq, input logic rdy, input logic sel,
                      input logic [1:0] tr, input logic [2:0] bu, input logic lk);
    req_port   = rq;
    HREADYM    = rdy;
    HSELM      = sel;
    HTRANSM    = tr;
    HBURSTM    = bu;
    HMASTLOCKM = lk;
    model_tick();
    @(posedge HCLK);
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once
  task automatic do_reset();
    #2 HRESET = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge HCLK);
    #1 HRESET = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge HCLK);
    #1;
    check_all();
    HRESET = 1'b0;

    // From reset, ports 1 and 2 request: port 1 wins
    step(4'b0110, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0);
    check_val("first_grant", 32'(rr_addr), 32'd1);
    check_val("first_chg",   32'(rr_chg),  32'd1);

    // Round-robin rotation with everyone requesting
    step(4'b1111, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0);
    check_val("rot_2", 32'(rr_addr), 32'd2);
    step(4'b1111, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0);
    check_val("rot_3", 32'(rr_addr), 32'd3);
    step(4'b1111, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0);
    check_val("rot_0", 32'(rr_addr), 32'd0);
    step(4'b1111, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0);
    check_val("rot_1", 32'(rr_addr), 32'd1);

    // INCR8 by port 1 with a BUSY and a wait state inside; port 2 waits
    step(4'b0110, 1'b1, 1'b1, 2'd2, 3'd5, 1'b0);
    check_val("incr8_ns", 32'(rr_addr), 32'd1);
    for (int b = 0; b < 3; b++) begin
      step(4'b0110, 1'b1, 1'b1, 2'd3, 3'd5, 1'b0);
      check_val("incr8_seq", 32'(rr_addr), 32'd1);
    end
    step(4'b0110, 1'b1, 1'b1, 2'd1, 3'd5, 1'b0);
    check_val("incr8_busy", 32'(rr_addr), 32'd1);
    step(4'b0110, 1'b0, 1'b1, 2'd3, 3'd5, 1'b0);
    check_val("incr8_wait", 32'(rr_addr), 32'd1);
    for (int b = 0; b < 3; b++) begin
      step(4'b0110, 1'b1, 1'b1, 2'd3, 3'd5, 1'b0);
      check_val("incr8_seq", 32'(rr_addr), 32'd1);
    end
    step(4'b0110, 1'b1, 1'b1, 2'd3, 3'd5, 1'b0);
    check_val("incr8_end", 32'(rr_addr), 32'd2);

    // Back-to-back short INCR bursts by port 2 with port 3 competing
    for (int b = 0; b < 3; b++) begin
      step(4'b1100, 1'b1, 1'b1, 2'd2, 3'd1, 1'b0);
      if (b < 2) step(4'b1100, 1'b1, 1'b1, 2'd3, 3'd1, 1'b0);
    end
    step(4'b1100, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0);

    // Fixed priority: lower requester preempts port 2
    do_reset();
    step(4'b0100, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0);
    check_val("fx_at2", 32'(fx_addr), 32'd2);
    step(4'b1001, 1'b1, 1'b1, 2'd0, 3'd0, 1'b0);
    check_val("fx_below", 32'(fx_addr), 32'd0);
    // Fixed priority: only a higher requester, slave deselected
    do_reset();
    step(4'b0100, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0);
    step(4'b1000, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0);
    check_val("fx_above", 32'(fx_addr), 32'd3);

    // Reset in the middle of a locked WRAP16
    step(4'b0001, 1'b1, 1'b1, 2'd2, 3'd6, 1'b1);
    step(4'b1111, 1'b1, 1'b1, 2'd3, 3'd6, 1'b1);
    step(4'b1111, 1'b1, 1'b1, 2'd3, 3'd6, 1'b1);
    do_reset();
    check_val("rst_rem", 32'(rr_rem), 32'd0);
    step(4'b1010, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0);
    check_val("post_rst", 32'(rr_addr), 32'd1);

    // Randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 800; n++) begin
      step(4'($urandom), ($urandom % 5) != 0, ($urandom % 4) != 0,
           2'($urandom), 3'($urandom), ($urandom % 10) == 0);
      if ($urandom % 80 == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
